// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: 16 lines x 32-byte blocks.
// Latency: load/store hits complete in the request cycle; a miss holds the CPU through MISS/[WRITEBACK]/FETCH/REFILL.
// Backpressure: cpu_stall_o holds the pipeline; memory side is a level-held request closed by a one-cycle mem_ack_i.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   cpu_req_i/_write_i  MEM-stage access present / store select
//   cpu_addr_i          byte address: tag [31:9], index [8:5], word [4:2]
//   cpu_data_i/_o       store data in / load data out (0 when no hit)
//   cpu_stall_o         pipeline stall
//   mem_req_o/_write_o  registered block request / writeback select
//   mem_addr_o/_data_o  registered block address / writeback block
//   mem_data_i/_ack_i   fetched block / completion pulse
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_FETCH,
        S_REFILL
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    valid_q, valid_d;
    logic [15:0]    dirty_q, dirty_d;
    logic [22:0]    tag_q  [16];
    logic [255:0]   data_q [16];

    logic           mem_req_q,   mem_req_d;
    logic           mem_write_q, mem_write_d;
    logic [31:0]    mem_addr_q,  mem_addr_d;
    logic [255:0]   mem_data_q,  mem_data_d;

    logic [22:0]    cpu_tag;
    logic [3:0]     cpu_idx;
    logic [2:0]     cpu_word;
    logic [255:0]   line_data;
    logic           hit;
    logic           victim_dirty;
    logic           store_hit;
    logic           fetch_done;

    // Byte offset within the word is irrelevant to a word-wide cache.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign cpu_tag      = cpu_addr_i[31:9];
    assign cpu_idx      = cpu_addr_i[8:5];
    assign cpu_word     = cpu_addr_i[4:2];
    assign line_data    = data_q[cpu_idx];
    assign hit          = valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
    assign victim_dirty = valid_q[cpu_idx] & dirty_q[cpu_idx];

    // Stores only commit from IDLE so a store that hits the freshly refilled
    // line is performed on the retry, not during REFILL.
    assign store_hit  = (state_q == S_IDLE) & cpu_req_i & cpu_write_i & hit;
    // An ack only counts once our request is actually on the bus.
    assign fetch_done = (state_q == S_FETCH) & mem_req_q & mem_ack_i;

    assign cpu_data_o  = (cpu_req_i & hit) ? line_data[{cpu_word, 5'b0} +: 32] : 32'h0;
    assign cpu_stall_o = (cpu_req_i & ~hit) | (state_q != S_IDLE);

    assign mem_req_o   = mem_req_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i && !hit) begin
                    state_d = S_MISS;
                end
                if (store_hit) begin
                    dirty_d[cpu_idx] = 1'b1;
                end
            end
            S_MISS: begin
                state_d = victim_dirty ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                // First cycle loads the request registers; they then hold until the ack.
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {tag_q[cpu_idx], cpu_idx, 5'b0};
                    mem_data_d  = data_q[cpu_idx];
                end else if (mem_ack_i) begin
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_data_d  = '0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {cpu_tag, cpu_idx, 5'b0};
                    mem_data_d  = '0;
                end else if (mem_ack_i) begin
                    mem_req_d        = 1'b0;
                    mem_write_d      = 1'b0;
                    mem_addr_d       = 32'h0;
                    mem_data_d       = '0;
                    valid_d[cpu_idx] = 1'b1;
                    dirty_d[cpu_idx] = 1'b0;
                    state_d          = S_REFILL;
                end
            end
            S_REFILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate them.
    always_ff @(posedge clk_i) begin
        if (fetch_done) begin
            data_q[cpu_idx] <= mem_data_i;
            tag_q[cpu_idx]  <= cpu_tag;
        end else if (store_hit) begin
            data_q[cpu_idx][{cpu_word, 5'b0} +: 32] <= cpu_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         resp_ack;
    logic         spur_ack;

    assign mem_ack_i = resp_ack | spur_ack;

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int mem_lat = 0;   // 0 = random memory latency

    typedef struct {
        bit           w;
        logic [31:0]  a;
        logic [255:0] d;
    } txn_t;

    txn_t        mem_q[$];          // expected memory transactions, in order
    logic [31:0] ld_q[$];           // expected load results, in order
    logic [31:0] arch[int unsigned];    // architectural word values written by stores
    logic [31:0] backing[int unsigned]; // main memory contents written back

    // Abstract cache occupancy: which block each index holds and whether it differs from memory.
    bit          rv[16];
    bit          rd[16];
    logic [22:0] rt[16];

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bdef(int unsigned w);
        return w * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [31:0] mem_rd(int unsigned w);
        return backing.exists(w) ? backing[w] : bdef(w);
    endfunction

    function automatic logic [31:0] arch_rd(int unsigned w);
        return arch.exists(w) ? arch[w] : mem_rd(w);
    endfunction

    function automatic logic [255:0] blk(logic [31:0] a, bit from_arch);
        logic [255:0] b;
        int unsigned  wi;
        wi = {2'b0, a[31:2]};
        for (int unsigned i = 0; i < 8; i++) begin
            b[32*i +: 32] = from_arch ? arch_rd(wi + i) : mem_rd(wi + i);
        end
        return b;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 16; i++) begin
            rv[i] = 1'b0;
            rd[i] = 1'b0;
            rt[i] = '0;
        end
        arch.delete();
        mem_q.delete();
        ld_q.delete();
    endtask

    // Predict the access from the abstract model, then present it to the DUT.
    task automatic issue(bit w, logic [31:0] a, logic [31:0] d);
        logic [3:0]  ix;
        logic [22:0] tg;
        bit          h;
        txn_t        t;
        ix = a[8:5];
        tg = a[31:9];
        h  = rv[ix] && (rt[ix] == tg);
        if (!h) begin
            if (rv[ix] && rd[ix]) begin
                t.w = 1'b1;
                t.a = {rt[ix], ix, 5'b0};
                t.d = blk(t.a, 1'b1);
                mem_q.push_back(t);
            end
            t.w = 1'b0;
            t.a = {tg, ix, 5'b0};
            t.d = '0;
            mem_q.push_back(t);
            rv[ix] = 1'b1;
            rt[ix] = tg;
            rd[ix] = 1'b0;
        end
        if (w) begin
            arch[{2'b0, a[31:2]}] = d;
            rd[ix] = 1'b1;
        end else begin
            ld_q.push_back(arch_rd({2'b0, a[31:2]}));
        end
        @(posedge clk_i);
        #1;
        cpu_req_i   = 1'b1;
        cpu_write_i = w;
        cpu_addr_i  = a;
        cpu_data_i  = d;
        @(negedge clk_i);
        chk("stall_on_issue", 256'(cpu_stall_o), 256'(!h));
    endtask

    task automatic complete();
        int n;
        n = 0;
        while (cpu_stall_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 300) chk("op_timeout", 256'(1'b1), 256'(1'b0));
    endtask

    task automatic op(bit w, logic [31:0] a, logic [31:0] d);
        issue(w, a, d);
        complete();
    endtask

    task automatic go_idle(int n);
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        repeat (n) @(posedge clk_i);
    endtask

    task automatic wait_mem(bit need_write);
        int n;
        n = 0;
        while (!(mem_req_o && (!need_write || mem_write_o)) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) chk("mem_req_timeout", 256'(1'b1), 256'(1'b0));
    endtask

    task automatic spurious_ack();
        @(posedge clk_i);
        #1 spur_ack = 1'b1;
        @(posedge clk_i);
        #1 spur_ack = 1'b0;
        @(negedge clk_i);
        chk("spur_no_req", 256'(mem_req_o), 256'(1'b0));
        chk("spur_no_stall", 256'(cpu_stall_o), 256'(1'b0));
    endtask

    // Load monitor: a load completes in any cycle it is presented without stall.
    always @(negedge clk_i) begin
        if (rst_i && cpu_req_i && !cpu_stall_o && !cpu_write_i) begin
            if (ld_q.size() == 0) chk("load_unexpected", 256'(1'b1), 256'(1'b0));
            else chk("load_data", 256'(cpu_data_o), 256'(ld_q.pop_front()));
        end else if (rst_i && !cpu_req_i) begin
            chk("data_zero_no_req", 256'(cpu_data_o), 256'(0));
        end
    end

    // Memory responder: checks each request against the expected stream and
    // acknowledges after mem_lat (or a random 1..4) cycles.
    initial begin
        bit           busy;
        bit           acked;
        int           cnt;
        logic [31:0]  a;
        logic         w;
        logic [255:0] d;
        txn_t         t;
        busy = 0;
        acked = 0;
        cnt = 0;
        a = '0;
        w = 1'b0;
        d = '0;
        resp_ack = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                busy = 0;
                acked = 0;
                resp_ack = 1'b0;
            end else if (acked) begin
                resp_ack = 1'b0;
                mem_data_i = '0;
                acked = 0;
                busy = 0;
                chk("req_low_after_ack", 256'(mem_req_o), 256'(1'b0));
                if (w) begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        backing[{2'b0, a[31:2]} + i] = d[32*i +: 32];
                    end
                end
            end else if (busy) begin
                chk("mem_stable", {mem_req_o, mem_write_o, mem_addr_o, mem_data_o[221:0]},
                                  {1'b1, w, a, d[221:0]});
                cnt--;
                if (cnt <= 0) begin
                    resp_ack = 1'b1;
                    acked = 1;
                    if (!w) mem_data_i = blk(a, 1'b0);
                end
            end else if (mem_req_o) begin
                busy = 1;
                a = mem_addr_o;
                w = mem_write_o;
                d = mem_data_o;
                cnt = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
                chk("mem_addr_aligned", 256'(a[4:0]), 256'(0));
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected", 256'(1'b1), 256'(1'b0));
                end else begin
                    t = mem_q.pop_front();
                    chk("mem_write", 256'(w), 256'(t.w));
                    chk("mem_addr", 256'(a), 256'(t.a));
                    if (t.w) chk("wb_data", d, t.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rtg;
        logic [3:0]  rix;
        logic [2:0]  rwd;
        rst_i = 1'b1;
        spur_ack = 1'b0;
        cpu_req_i = 1'b0;
        cpu_write_i = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        backing[32'h44 >> 2] = 32'hDEADBEEF;
        reset_model();
        #1 rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_mem_req", 256'(mem_req_o), 256'(1'b0));
        chk("rst_mem_write", 256'(mem_write_o), 256'(1'b0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_data", mem_data_o, 256'(0));
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        chk("stall_after_reset", 256'(cpu_stall_o), 256'(1'b0));

        // Cold load, write hit, conflicting dirty miss.
        mem_lat = 3;
        op(1'b0, 32'h44, 32'h0);
        mem_lat = 0;
        op(1'b1, 32'h44, 32'h12345678);
        op(1'b0, 32'h44, 32'h0);
        op(1'b0, 32'h244, 32'h0);

        // Store miss on a clean line, read back, then evict it dirty.
        op(1'b1, 32'h1008, 32'hCAFEF00D);
        op(1'b0, 32'h1008, 32'h0);
        op(1'b0, 32'h0008, 32'h0);

        // Stray ack while idle must not disturb anything.
        go_idle(1);
        spurious_ack();
        op(1'b0, 32'h0008, 32'h0);

        // Request withdrawn mid-miss: refill still completes.
        issue(1'b0, 32'h400, 32'h0);
        void'(ld_q.pop_back());
        wait_mem(1'b0);
        @(posedge clk_i);
        #1 cpu_req_i = 1'b0;
        repeat (30) @(negedge clk_i);
        chk("abandon_idle_stall", 256'(cpu_stall_o), 256'(1'b0));
        op(1'b0, 32'h404, 32'h0);

        // Reset in the middle of a writeback.
        op(1'b1, 32'h244, 32'hA5A5A5A5);
        issue(1'b0, 32'h44, 32'h0);
        wait_mem(1'b1);
        #2 rst_i = 1'b0;
        #1 chk("async_reset_req", 256'(mem_req_o), 256'(1'b0));
        cpu_req_i = 1'b0;
        reset_model();
        repeat (2) @(negedge clk_i);
        #1 rst_i = 1'b1;
        spurious_ack();
        op(1'b0, 32'h44, 32'h0);

        // Randomized traffic over a few conflicting tags.
        for (int k = 0; k < 300; k++) begin
            rtg = 2'($urandom_range(0, 3));
            rix = 4'($urandom_range(0, 3));
            rwd = 3'($urandom_range(0, 7));
            ra  = {21'b0, rtg, rix, rwd, 2'b00};
            op(1'($urandom_range(0, 1)), ra, $urandom);
            if ($urandom_range(0, 3) == 0) go_idle(int'($urandom_range(0, 2)));
        end

        go_idle(10);
        chk("loads_outstanding", 256'(ld_q.size()), 256'(0));
        chk("mem_outstanding", 256'(mem_q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
